// File: rtl/simon_pkg.sv
// simon_pkg: shared Simon game types, channel limits and width helpers.
// Used by the sequence engine, LED controller and LCD message sequencer.
package simon_pkg;

  localparam int N_CH_MIN = 2;
  localparam int N_CH_MAX = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_SHOW_ON,
    S_SHOW_OFF,
    S_INPUT,
    S_GAP,
    S_WIN,
    S_LOSE
  } simon_state_t;

  // Bits needed to index n values, never less than one.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Phase counter reload: a length of 0 behaves like 1.
  function automatic logic [31:0] phase_load(input int cyc);
    return (cyc <= 1) ? 32'd0 : 32'(cyc - 1);
  endfunction

endpackage

// File: rtl/simon_seq_engine_if.sv
// simon_seq_engine_if: game control, LFSR, button and LED signals.
// master = sequence engine, slave = surrounding game logic.
interface simon_seq_engine_if
  import simon_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int MAX_LEN = 32
);
  localparam int CW = width_of(N_CH);
  localparam int LW = width_of(MAX_LEN + 1);

  logic          start;
  logic [CW-1:0] rnd;
  logic          rnd_step;
  logic          btn_valid;
  logic [CW-1:0] btn_id;
  logic          led_en;
  logic [CW-1:0] led_ch;
  logic          busy;
  logic          await_input;
  logic [LW-1:0] score;
  logic          win;
  logic          lose;

  modport master (
    input  start, rnd, btn_valid, btn_id,
    output rnd_step, led_en, led_ch, busy,
    output await_input, score, win, lose
  );

  modport slave (
    output start, rnd, btn_valid, btn_id,
    input  rnd_step, led_en, led_ch, busy,
    input  await_input, score, win, lose
  );

endinterface

// File: rtl/simon_seq_ram.sv
// simon_seq_ram: colour sequence store, one entry per round.
// Synchronous write, asynchronous read; contents are not reset.
module simon_seq_ram #(
  parameter int DEPTH = 32,
  parameter int W     = 2,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Append the newly drawn colour.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Out-of-range addresses read as channel 0.
  always_comb begin
    rdata = '0;
    if (raddr < AW'(DEPTH)) rdata = mem[raddr];
  end

endmodule

// File: rtl/simon_seq_engine.sv
// simon_seq_engine: Simon core - grow sequence, play it back, judge presses.
// Define SIMON_INPUT_TIMEOUT_EN to lose on a slow press (TIMEOUT_CYCLES).
module simon_seq_engine
  import simon_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int MAX_LEN        = 32,
  parameter int SHOW_CYCLES    = 25_000_000,
  parameter int GAP_CYCLES     = 12_500_000,
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input logic               clk,
  input logic               reset,
  simon_seq_engine_if.master bus
);

  localparam int CW = width_of(N_CH);
  localparam int LW = width_of(MAX_LEN + 1);
  localparam logic [31:0] SHOW_LD = phase_load(SHOW_CYCLES);
  localparam logic [31:0] GAP_LD  = phase_load(GAP_CYCLES);
  localparam logic [LW-1:0] MAXL  = LW'(MAX_LEN);

  simon_state_t  state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [LW-1:0] score_q, score_d;
  logic [31:0]   cnt_q, cnt_d;
`ifdef SIMON_INPUT_TIMEOUT_EN
  localparam logic [31:0] TMO_LD = phase_load(TIMEOUT_CYCLES);
  logic [31:0]   tmo_q, tmo_d;
`endif

  logic [CW-1:0] ch;
  logic [CW-1:0] rdata;
  logic [CW-1:0] led_nx;
  logic [LW-1:0] show_idx;
  logic [LW-1:0] raddr;
  logic          ram_we;
  logic          last;
  logic          hit;

  // Fold out-of-range random values back into the channel range.
  always_comb begin
    ch = bus.rnd;
    if (int'(bus.rnd) >= N_CH) ch = CW'(int'(bus.rnd) - N_CH);
  end

  // Playback reads the step about to be lit; INPUT reads the expected step.
  always_comb begin
    show_idx = (state_q == S_ADD) ? '0 : idx_q + LW'(1);
    raddr    = (state_q == S_INPUT) ? idx_q : show_idx;
    ram_we   = (state_q == S_ADD) && (len_q < MAXL);
    last     = (idx_q == len_q - LW'(1));
    hit      = (bus.btn_id == rdata);
    led_nx   = (state_q == S_ADD && len_q == '0) ? ch : rdata;
  end

  simon_seq_ram #(
    .DEPTH (MAX_LEN),
    .W     (CW),
    .AW    (LW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (len_q),
    .wdata (ch),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Game sequencing and phase timing.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    score_d = score_q;
    cnt_d   = cnt_q;
`ifdef SIMON_INPUT_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    unique case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (bus.start) begin
          len_d   = '0;
          idx_d   = '0;
          score_d = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        if (len_q < MAXL) len_d = len_q + LW'(1);
        idx_d   = '0;
        cnt_d   = SHOW_LD;
        state_d = S_SHOW_ON;
      end
      S_SHOW_ON: begin
        if (cnt_q == '0) begin
          cnt_d   = GAP_LD;
          state_d = S_SHOW_OFF;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_SHOW_OFF: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 32'd1;
        end else if (last) begin
          idx_d   = '0;
          state_d = S_INPUT;
`ifdef SIMON_INPUT_TIMEOUT_EN
          tmo_d   = TMO_LD;
`endif
        end else begin
          idx_d   = idx_q + LW'(1);
          cnt_d   = SHOW_LD;
          state_d = S_SHOW_ON;
        end
      end
      S_INPUT: begin
        if (bus.btn_valid) begin
          if (!hit) begin
            state_d = S_LOSE;
          end else if (!last) begin
            idx_d = idx_q + LW'(1);
`ifdef SIMON_INPUT_TIMEOUT_EN
            tmo_d = TMO_LD;
`endif
          end else begin
            if (score_q < MAXL) score_d = score_q + LW'(1);
            cnt_d   = GAP_LD;
            state_d = (len_q == MAXL) ? S_WIN : S_GAP;
          end
        end
`ifdef SIMON_INPUT_TIMEOUT_EN
        else if (tmo_q == '0) begin
          state_d = S_LOSE;
        end else begin
          tmo_d = tmo_q - 32'd1;
        end
`endif
      end
      S_GAP: begin
        if (cnt_q == '0) state_d = S_ADD;
        else cnt_d = cnt_q - 32'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, round bookkeeping and phase counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      score_q <= '0;
      cnt_q   <= '0;
`ifdef SIMON_INPUT_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      score_q <= score_d;
      cnt_q   <= cnt_d;
`ifdef SIMON_INPUT_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  // Registered outputs decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.led_en      <= 1'b0;
      bus.led_ch      <= '0;
      bus.rnd_step    <= 1'b0;
      bus.busy        <= 1'b0;
      bus.await_input <= 1'b0;
      bus.win         <= 1'b0;
      bus.lose        <= 1'b0;
    end else begin
      bus.led_en   <= (state_d == S_SHOW_ON);
      if (state_d == S_SHOW_ON && state_q != S_SHOW_ON)
        bus.led_ch <= led_nx;
      bus.rnd_step <= (state_d == S_ADD);
      bus.busy     <= (state_d == S_ADD) ||
                      (state_d == S_SHOW_ON) ||
                      (state_d == S_SHOW_OFF);
      bus.await_input <= (state_d == S_INPUT);
      bus.win      <= (state_d == S_WIN);
      bus.lose     <= (state_d == S_LOSE);
    end
  end

  assign bus.score = score_q;

endmodule

// File: tb/tb_simon_seq_engine.sv
// tb_simon_seq_engine: directed game scenarios with a scoreboard monitor.
// Builds with or without SIMON_INPUT_TIMEOUT_EN.
module tb_simon_seq_engine;

  localparam int EV_LED   = 0;
  localparam int EV_SCORE = 1;
  localparam int EV_WIN   = 2;
  localparam int EV_LOSE  = 3;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  simon_seq_engine_if #(.N_CH(4), .MAX_LEN(3)) bus ();
  simon_seq_engine_if #(.N_CH(3), .MAX_LEN(3)) bus3 ();

  simon_seq_engine #(
    .N_CH(4), .MAX_LEN(3), .SHOW_CYCLES(4),
    .GAP_CYCLES(2), .TIMEOUT_CYCLES(10)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  simon_seq_engine #(
    .N_CH(3), .MAX_LEN(3), .SHOW_CYCLES(4),
    .GAP_CYCLES(2), .TIMEOUT_CYCLES(10)
  ) dut3 (
    .clk(clk), .reset(reset), .bus(bus3)
  );

  int checks = 0;
  int errors = 0;
  ev_t exp_q[$];
  bit mon_en = 1'b0;
  int rk = 0;
  int steps = 0;
  int rtab[5] = '{2, 1, 3, 1, 2};

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  function automatic void push(input int k, input int v);
    exp_q.push_back('{kind: k, val: v});
  endfunction

  task automatic expect_ev(input int k, input int v);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got kind %0d val %0d, required none", k, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v) begin
        errors++;
        $display("FAIL sb_event: got kind %0d val %0d, required kind %0d val %0d",
                 k, v, e.kind, e.val);
      end
    end
  endtask

  // LFSR stand-in: advance after the ADD cycle that consumed the value.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.rnd_step) begin
        @(posedge clk);
        #1;
        rk = (rk + 1) % 5;
        bus.rnd = 2'(rtab[rk]);
        steps++;
      end
    end
  end

  // Monitor: LED pulses (channel*100+length), score changes, win/lose rises.
  initial begin
    int lit = 0;
    int cur = 0;
    logic pled = 1'b0;
    logic pwin = 1'b0;
    logic plose = 1'b0;
    int pscore = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.led_en) begin
        lit++;
        cur = int'(bus.led_ch);
      end else if (pled) begin
        if (mon_en) expect_ev(EV_LED, cur * 100 + lit);
        lit = 0;
      end
      if (int'(bus.score) != pscore && mon_en)
        expect_ev(EV_SCORE, int'(bus.score));
      if (bus.win && !pwin && mon_en) expect_ev(EV_WIN, 1);
      if (bus.lose && !plose && mon_en) expect_ev(EV_LOSE, 1);
      pled   = bus.led_en;
      pwin   = bus.win;
      plose  = bus.lose;
      pscore = int'(bus.score);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_await(input string nm);
    int n = 0;
    while (!bus.await_input && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.await_input) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic wait_led(input string nm);
    int n = 0;
    while (!bus.led_en && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.led_en) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic press(input int id);
    bus.btn_valid = 1'b1;
    bus.btn_id = 2'(id);
    @(negedge clk);
    bus.btn_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic set_rnd0();
    rk = 0;
    bus.rnd = 2'(rtab[0]);
  endtask

  initial begin
    int n;
    int seq[3] = '{2, 1, 3};
    bus.start = 1'b0;
    bus.btn_valid = 1'b0;
    bus.btn_id = '0;
    bus3.start = 1'b0;
    bus3.btn_valid = 1'b0;
    bus3.btn_id = '0;
    bus3.rnd = 2'd3;
    set_rnd0();
    tick(3);

    chk("rst_led_en", int'(bus.led_en), 0);
    chk("rst_led_ch", int'(bus.led_ch), 0);
    chk("rst_rnd_step", int'(bus.rnd_step), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_await", int'(bus.await_input), 0);
    chk("rst_score", int'(bus.score), 0);
    chk("rst_win_lose", int'({bus.win, bus.lose}), 0);
    reset = 1'b0;
    tick(2);

    // Game 1: full win with sequence 2,1,3.
    mon_en = 1'b1;
    steps = 0;
    push(EV_LED, 204);
    pulse_start();
    chk("add_busy", int'(bus.busy), 1);
    chk("add_rnd_step", int'(bus.rnd_step), 1);
    chk("add_led_off", int'(bus.led_en), 0);
    tick(1);
    chk("start_led_latency", int'(bus.led_en), 1);
    chk("r1_led_ch", int'(bus.led_ch), 2);
    n = 0;
    while (bus.led_en && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("r1_show_len", n, 4);
    n = 0;
    while (!bus.await_input && !bus.led_en && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("r1_gap_len", n, 2);
    chk("r1_await", int'(bus.await_input), 1);
    chk("r1_steps", steps, 1);

    for (int r = 1; r <= 3; r++) begin
      wait_await("g1_wait");
      for (int i = 0; i < r; i++) begin
        if (i == r - 1) begin
          push(EV_SCORE, r);
          if (r == 3) push(EV_WIN, 1);
          else for (int j = 0; j <= r; j++) push(EV_LED, seq[j] * 100 + 4);
        end
        press(seq[i]);
        tick(1);
      end
    end
    tick(3);
    chk("g1_win", int'(bus.win), 1);
    chk("g1_led_off", int'(bus.led_en), 0);
    chk("g1_score", int'(bus.score), 3);
    chk("g1_steps", steps, 3);
    press(1);
    tick(10);
    chk("g1_win_holds", int'(bus.win), 1);
    chk("g1_idle_busy", int'(bus.busy), 0);

    // Game 2: wrong press in round 2.
    set_rnd0();
    push(EV_SCORE, 0);
    push(EV_LED, 204);
    pulse_start();
    wait_await("g2_r1");
    push(EV_SCORE, 1);
    push(EV_LED, 204);
    push(EV_LED, 104);
    press(2);
    tick(1);
    wait_await("g2_r2");
    press(2);
    tick(1);
    push(EV_LOSE, 1);
    press(3);
    chk("g2_lose_next", int'(bus.lose), 1);
    chk("g2_score_hold", int'(bus.score), 1);
    tick(1);
    press(1);
    tick(1);
    press(2);
    tick(3);
    chk("g2_lose_holds", int'(bus.lose), 1);
    chk("g2_score_after", int'(bus.score), 1);
    chk("g2_await_off", int'(bus.await_input), 0);
    chk("sb_drained", exp_q.size(), 0);
    mon_en = 1'b0;

    // Game 3: reset during playback, then reset vs start.
    set_rnd0();
    pulse_start();
    wait_await("g3_r1");
    press(2);
    tick(1);
    chk("g3_score1", int'(bus.score), 1);
    wait_led("g3_show");
    tick(1);
    reset = 1'b1;
    tick(1);
    chk("g3_rst_led_en", int'(bus.led_en), 0);
    chk("g3_rst_led_ch", int'(bus.led_ch), 0);
    chk("g3_rst_busy", int'(bus.busy), 0);
    chk("g3_rst_score", int'(bus.score), 0);
    chk("g3_rst_misc", int'({bus.await_input, bus.rnd_step, bus.win, bus.lose}), 0);
    bus.start = 1'b1;
    tick(2);
    chk("g3_reset_wins", int'(bus.busy), 0);
    reset = 1'b0;
    tick(1);
    bus.start = 1'b0;
    chk("g3_restart_busy", int'(bus.busy), 1);
    chk("g3_restart_score", int'(bus.score), 0);
    wait_await("g3_to");
    n = 0;
`ifdef SIMON_INPUT_TIMEOUT_EN
    while (bus.await_input && n < 2000) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_len", n, 10);
    chk("timeout_lose", int'(bus.lose), 1);
`else
    while (bus.await_input && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("no_timeout_len", n, 1000);
    chk("no_timeout_await", int'(bus.await_input), 1);
    chk("no_timeout_lose", int'(bus.lose), 0);
`endif

    // Three-channel core: rnd 3 folds to channel 0.
    bus3.start = 1'b1;
    tick(1);
    bus3.start = 1'b0;
    tick(1);
    chk("n3_led_en", int'(bus3.led_en), 1);
    chk("n3_led_ch", int'(bus3.led_ch), 0);
    n = 0;
    while (!bus3.await_input && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("n3_await", int'(bus3.await_input), 1);
    bus3.btn_valid = 1'b1;
    bus3.btn_id = 2'd0;
    tick(1);
    bus3.btn_valid = 1'b0;
    chk("n3_score", int'(bus3.score), 1);
    chk("n3_not_lost", int'(bus3.lose), 0);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
